// File: rtl/phy_mdio_pkg.sv
// Shared MDIO (clause 22) frame definitions: FSM states, frame field constants, command struct.
// Frame builder packs the post-preamble 32-bit serial word, MSB first on the wire.
package phy_mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam int HDR_BITS   = 14;
    localparam int TA_BITS    = 2;
    localparam int DATA_BITS  = 16;
    localparam int FRAME_BITS = HDR_BITS + TA_BITS + DATA_BITS;

    typedef struct packed {
        logic        write;
        logic [4:0]  phy_addr;
        logic [4:0]  reg_addr;
        logic [15:0] wdata;
    } mdio_cmd_t;

    // Read frames fill TA/DATA with ones so mdio_o idles high while the PHY owns the line.
    function automatic logic [FRAME_BITS-1:0] build_frame(input mdio_cmd_t c);
        if (c.write)
            return {MDIO_ST, MDIO_OP_WR, c.phy_addr, c.reg_addr, MDIO_TA_WR, c.wdata};
        return {MDIO_ST, MDIO_OP_RD, c.phy_addr, c.reg_addr, 2'b11, 16'hFFFF};
    endfunction

endpackage

// File: rtl/phy_mdio_master_if.sv
// Command/response bus of the MDIO master; master = command issuer, slave = the MDIO engine.
// Single-beat valid/ready command, one-cycle response pulse with no backpressure.
interface phy_mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_ta_err;
    logic        busy;

    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_ta_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_ta_err, busy
    );
endinterface

// File: rtl/mdio_clk_div.sv
// MDC generator: per bit, low MDC_DIV/2 cycles then high MDC_DIV/2; held low with phase 0 while !run.
// fall_stb marks the last cycle of a bit (MDC falls next cycle), rise_stb the first MDC-high cycle.
module mdio_clk_div #(
    parameter int MDC_DIV = 10
) (
    input  logic clk_25Mz,
    input  logic reset_N,
    input  logic run,
    output logic mdc,
    output logic fall_stb,
    output logic rise_stb
);
    localparam int PW   = $clog2(MDC_DIV);
    localparam int HALF = MDC_DIV / 2;

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;

    always_comb begin
        phase_nxt = '0;
        if (run && (phase != PW'(MDC_DIV - 1)))
            phase_nxt = phase + 1'b1;
    end

    // MDC is registered from the next phase so the pin never glitches on counter decode.
    always_ff @(posedge clk_25Mz or negedge reset_N) begin
        if (!reset_N) begin
            phase <= '0;
            mdc   <= 1'b0;
        end else begin
            phase <= phase_nxt;
            mdc   <= (phase_nxt >= PW'(HALF));
        end
    end

    assign fall_stb = run && (phase == PW'(MDC_DIV - 1));
    assign rise_stb = run && (phase == PW'(HALF));

endmodule

// File: rtl/phy_mdio_master.sv
// Clause-22 MDIO master: one command -> one frame, rsp_valid (PRE_LEN+32)*MDC_DIV+1 cycles after accept.
// cmd_ready only in IDLE with enable high; commands offered while busy are dropped, rsp cannot stall.
module phy_mdio_master
    import phy_mdio_pkg::*;
#(
    parameter int MDC_DIV = 10,
    parameter int PRE_LEN = 32
) (
    input  logic             clk_25Mz,
    input  logic             reset_N,
    input  logic             enable,
    phy_mdio_master_if.slave cmd_if,
    output logic             MDC,
    output logic             mdio_o,
    output logic             mdio_oe,
    input  logic             mdio_i
);
    localparam logic [5:0] PRE_LAST = 6'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);

    state_t                state, state_nxt;
    logic [5:0]            bit_cnt;
    logic                  last_bit;
    logic                  run, fall_stb, rise_stb;
    logic                  cmd_ready, accept;
    logic                  wr_q, ta_bit;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [15:0]           rx_sr;
    logic [15:0]           rsp_rdata;
    logic                  rsp_ta_err;
    mdio_cmd_t             cmd;

    assign cmd       = {cmd_if.cmd_write, cmd_if.cmd_phy_addr, cmd_if.cmd_reg_addr, cmd_if.cmd_wdata};
    assign run       = state inside {S_PRE, S_HDR, S_TA, S_DATA};
    assign cmd_ready = reset_N && enable && (state == S_IDLE);
    assign accept    = cmd_if.cmd_valid && cmd_ready;

    mdio_clk_div #(.MDC_DIV(MDC_DIV)) u_clk_div (
        .clk_25Mz (clk_25Mz),
        .reset_N  (reset_N),
        .run      (run),
        .mdc      (MDC),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    always_comb begin
        case (state)
            S_PRE:   last_bit = (bit_cnt == PRE_LAST);
            S_HDR:   last_bit = (bit_cnt == 6'(HDR_BITS - 1));
            S_TA:    last_bit = (bit_cnt == 6'(TA_BITS - 1));
            S_DATA:  last_bit = (bit_cnt == 6'(DATA_BITS - 1));
            default: last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_25Mz or negedge reset_N) begin
        if (!reset_N) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // States only advance on fall_stb, so pin outputs decoded from state/tx_sr move with MDC falling.
    always_comb begin
        state_nxt = state;
        mdio_o    = 1'b1;
        mdio_oe   = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nxt = (PRE_LEN == 0) ? S_HDR : S_PRE;
            S_PRE: begin
                mdio_oe = 1'b1;
                if (fall_stb && last_bit) state_nxt = S_HDR;
            end
            S_HDR: begin
                mdio_o  = tx_sr[FRAME_BITS-1];
                mdio_oe = 1'b1;
                if (fall_stb && last_bit) state_nxt = S_TA;
            end
            S_TA: begin
                mdio_o  = tx_sr[FRAME_BITS-1];
                mdio_oe = wr_q;
                if (fall_stb && last_bit) state_nxt = S_DATA;
            end
            S_DATA: begin
                mdio_o  = tx_sr[FRAME_BITS-1];
                mdio_oe = wr_q;
                if (fall_stb && last_bit) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25Mz or negedge reset_N) begin
        if (!reset_N) begin
            bit_cnt    <= '0;
            wr_q       <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            ta_bit     <= 1'b0;
            rsp_rdata  <= '0;
            rsp_ta_err <= 1'b0;
        end else begin
            if (accept) begin
                wr_q  <= cmd.write;
                tx_sr <= build_frame(cmd);
            end else if (fall_stb && (state inside {S_HDR, S_TA, S_DATA})) begin
                tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b1};
            end
            if (fall_stb)
                bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
            if (rise_stb && (state == S_TA) && (bit_cnt == 6'd1))
                ta_bit <= mdio_i;
            if (rise_stb && (state == S_DATA))
                rx_sr <= {rx_sr[14:0], mdio_i};
            // The last data bit was sampled mid-bit, so rx_sr is complete at the DATA exit.
            if ((state == S_DATA) && fall_stb && last_bit) begin
                rsp_rdata  <= wr_q ? 16'h0000 : rx_sr;
                rsp_ta_err <= !wr_q && ta_bit;
            end
        end
    end

    assign cmd_if.cmd_ready  = cmd_ready;
    assign cmd_if.busy       = (state != S_IDLE);
    assign cmd_if.rsp_valid  = (state == S_DONE);
    assign cmd_if.rsp_rdata  = rsp_rdata;
    assign cmd_if.rsp_ta_err = rsp_ta_err;

endmodule

// File: tb/tb_phy_mdio_master.sv
// Directed bench: default MDIO master (32-bit preamble, /10) plus a short-frame /4 instance.
module tb_phy_mdio_master;

    logic clk_25Mz = 1'b0;
    logic reset_N;
    logic enable, enable_b;
    logic mdc_a, mdo_a, mdoe_a, mdi_a;
    logic mdc_b, mdo_b, mdoe_b, mdi_b;

    int checks = 0;
    int errors = 0;

    logic [63:0] rec_o, rec_oe;
    int          rises, rsp_cyc, ready_seen, stable_viol;
    logic [15:0] got_rdata;
    logic        got_ta;

    phy_mdio_master_if ifa();
    phy_mdio_master_if ifb();

    phy_mdio_master u_dut (
        .clk_25Mz (clk_25Mz), .reset_N (reset_N), .enable (enable), .cmd_if (ifa),
        .MDC (mdc_a), .mdio_o (mdo_a), .mdio_oe (mdoe_a), .mdio_i (mdi_a)
    );

    phy_mdio_master #(.MDC_DIV(4), .PRE_LEN(0)) u_dut_short (
        .clk_25Mz (clk_25Mz), .reset_N (reset_N), .enable (enable_b), .cmd_if (ifb),
        .MDC (mdc_b), .mdio_o (mdo_b), .mdio_oe (mdoe_b), .mdio_i (mdi_b)
    );

    always #20 clk_25Mz = ~clk_25Mz;

    // Runs a frame of DUT A from cycle 1 (acceptance edge just passed) until rsp_valid, acting as the PHY.
    task automatic run_frame(input logic [63:0] phy_resp, input int en_drop_bit);
        logic prev_mdc, prev_o, prev_oe;
        rec_o = '0; rec_oe = '0; rises = 0; rsp_cyc = 0; ready_seen = 0; stable_viol = 0;
        got_rdata = '0; got_ta = 1'b0;
        prev_mdc = 1'b0; prev_o = 1'b1; prev_oe = 1'b0;
        for (int cyc = 1; cyc <= 1000 && rsp_cyc == 0; cyc++) begin
            if (mdc_a && !prev_mdc) begin
                if (rises < 64) begin
                    rec_o[63-rises]  = mdo_a;
                    rec_oe[63-rises] = mdoe_a;
                end
                rises++;
            end
            if ((mdo_a !== prev_o || mdoe_a !== prev_oe) && !(prev_mdc && !mdc_a) && cyc != 1)
                stable_viol++;
            if (ifa.cmd_ready) ready_seen++;
            if (ifa.rsp_valid) begin
                rsp_cyc   = cyc;
                got_rdata = ifa.rsp_rdata;
                got_ta    = ifa.rsp_ta_err;
            end
            if (rises == en_drop_bit) enable = 1'b0;
            if (!mdc_a) mdi_a = (rises < 64) ? phy_resp[63-rises] : 1'b1;
            prev_mdc = mdc_a; prev_o = mdo_a; prev_oe = mdoe_a;
            @(posedge clk_25Mz); #1;
        end
        mdi_a = 1'b1;
    endtask

    task automatic issue_a(input logic wr, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd);
        ifa.cmd_write = wr; ifa.cmd_phy_addr = phy; ifa.cmd_reg_addr = rg; ifa.cmd_wdata = wd;
        ifa.cmd_valid = 1'b1;
        @(posedge clk_25Mz); #1;
        ifa.cmd_valid = 1'b0;
        ifa.cmd_write = ~wr; ifa.cmd_phy_addr = ~phy; ifa.cmd_reg_addr = ~rg; ifa.cmd_wdata = ~wd;
    endtask

    task automatic test_reset;
        reset_N = 1'b0; enable = 1'b1; enable_b = 1'b1;
        repeat (3) @(posedge clk_25Mz);
        #1;
        checks++; if (mdc_a !== 1'b0) begin errors++; $display("FAIL rst_mdc got %b exp 0", mdc_a); end
        checks++; if (mdoe_a !== 1'b0) begin errors++; $display("FAIL rst_oe got %b exp 0", mdoe_a); end
        checks++; if (mdo_a !== 1'b1) begin errors++; $display("FAIL rst_o got %b exp 1", mdo_a); end
        checks++; if (ifa.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ifa.cmd_ready); end
        checks++; if (ifa.busy !== 1'b0 || ifa.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_vld got %b%b exp 00", ifa.busy, ifa.rsp_valid); end
        checks++; if (ifa.rsp_rdata !== 16'h0 || ifa.rsp_ta_err !== 1'b0) begin errors++; $display("FAIL rst_rsp got %h/%b exp 0000/0", ifa.rsp_rdata, ifa.rsp_ta_err); end
        checks++; if (mdc_b !== 1'b0 || ifb.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_short got %b%b exp 00", mdc_b, ifb.cmd_ready); end
        reset_N = 1'b1;
        #1;
        checks++; if (ifa.cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst got %b exp 1", ifa.cmd_ready); end
        @(posedge clk_25Mz); #1;
    endtask

    task automatic test_read;
        logic [45:0] exp_hdr;
        exp_hdr = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h01, 5'h02};
        issue_a(1'b0, 5'h01, 5'h02, 16'h0000);
        run_frame({32'hFFFF_FFFF, 14'h3FFF, 2'b10, 16'h0141}, -1);
        checks++; if (rsp_cyc != 641) begin errors++; $display("FAIL rd_latency got %0d exp 641", rsp_cyc); end
        checks++; if (rec_o[63:18] !== exp_hdr) begin errors++; $display("FAIL rd_hdr got %h exp %h", rec_o[63:18], exp_hdr); end
        checks++; if (rec_oe !== {{46{1'b1}}, {18{1'b0}}}) begin errors++; $display("FAIL rd_oe got %h exp %h", rec_oe, {{46{1'b1}}, {18{1'b0}}}); end
        checks++; if (got_rdata !== 16'h0141 || got_ta !== 1'b0) begin errors++; $display("FAIL rd_data got %h/%b exp 0141/0", got_rdata, got_ta); end
        checks++; if (stable_viol != 0) begin errors++; $display("FAIL rd_stable got %0d exp 0", stable_viol); end
        repeat (3) @(posedge clk_25Mz);
        #1;
        checks++; if (ifa.rsp_rdata !== 16'h0141) begin errors++; $display("FAIL rd_hold got %h exp 0141", ifa.rsp_rdata); end
    endtask

    task automatic test_write;
        logic [63:0] exp;
        exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00001, 5'b00000, 2'b10, 16'h8000};
        issue_a(1'b1, 5'h01, 5'h00, 16'h8000);
        run_frame({64{1'b1}}, -1);
        checks++; if (rsp_cyc != 641) begin errors++; $display("FAIL wr_latency got %0d exp 641", rsp_cyc); end
        checks++; if (rises != 64) begin errors++; $display("FAIL wr_mdc_periods got %0d exp 64", rises); end
        checks++; if (rec_o !== exp) begin errors++; $display("FAIL wr_serial got %h exp %h", rec_o, exp); end
        checks++; if (rec_oe !== {64{1'b1}}) begin errors++; $display("FAIL wr_oe got %h exp all ones", rec_oe); end
        checks++; if (got_rdata !== 16'h0 || got_ta !== 1'b0) begin errors++; $display("FAIL wr_rsp got %h/%b exp 0000/0", got_rdata, got_ta); end
        checks++; if (stable_viol != 0 || ready_seen != 0) begin errors++; $display("FAIL wr_stable_ready got %0d/%0d exp 0/0", stable_viol, ready_seen); end
        checks++; if (mdo_a !== 1'b1 || mdoe_a !== 1'b0 || mdc_a !== 1'b0) begin errors++; $display("FAIL wr_idle_line got %b%b%b exp 100", mdo_a, mdoe_a, mdc_a); end
    endtask

    task automatic test_no_phy;
        issue_a(1'b0, 5'h07, 5'h03, 16'h0000);
        run_frame({64{1'b1}}, -1);
        checks++; if (rsp_cyc != 641) begin errors++; $display("FAIL nophy_latency got %0d exp 641", rsp_cyc); end
        checks++; if (got_rdata !== 16'hFFFF || got_ta !== 1'b1) begin errors++; $display("FAIL nophy_rsp got %h/%b exp FFFF/1", got_rdata, got_ta); end
    endtask

    task automatic test_enable_hold;
        int viol;
        ifa.cmd_write = 1'b1; ifa.cmd_phy_addr = 5'h03; ifa.cmd_reg_addr = 5'h04; ifa.cmd_wdata = 16'h1234;
        ifa.cmd_valid = 1'b1;
        @(posedge clk_25Mz); #1;
        run_frame({64{1'b1}}, 20);
        checks++; if (rsp_cyc != 641) begin errors++; $display("FAIL hold_latency got %0d exp 641", rsp_cyc); end
        checks++; if (ready_seen != 0) begin errors++; $display("FAIL hold_busy_ready got %0d exp 0", ready_seen); end
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifa.cmd_ready !== 1'b0 || ifa.busy !== 1'b0) viol++;
            @(posedge clk_25Mz); #1;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL hold_blocked got %0d exp 0", viol); end
        enable = 1'b1;
        @(posedge clk_25Mz); #1;
        ifa.cmd_valid = 1'b0;
        checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL hold_reenable got %b exp 1", ifa.busy); end
    endtask

    // Continues the frame accepted at the end of test_enable_hold (a write).
    task automatic test_reset_abort;
        int n, viol;
        logic prev;
        logic [63:0] exp;
        n = 0; prev = 1'b0;
        for (int c = 0; c < 2000 && n < 41; c++) begin
            @(posedge clk_25Mz); #1;
            if (mdc_a && !prev) n++;
            prev = mdc_a;
        end
        checks++; if (n != 41 || mdc_a !== 1'b1 || mdoe_a !== 1'b1) begin errors++; $display("FAIL abort_reach got %0d/%b%b exp 41/11", n, mdc_a, mdoe_a); end
        reset_N = 1'b0;
        #1;
        checks++; if (mdc_a !== 1'b0 || mdoe_a !== 1'b0 || mdo_a !== 1'b1) begin errors++; $display("FAIL abort_pins got %b%b%b exp 001", mdc_a, mdoe_a, mdo_a); end
        checks++; if (ifa.busy !== 1'b0 || ifa.cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_state got %b%b exp 00", ifa.busy, ifa.cmd_ready); end
        viol = 0;
        repeat (3) begin
            @(posedge clk_25Mz); #1;
            if (ifa.rsp_valid !== 1'b0 || ifa.busy !== 1'b0) viol++;
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL abort_no_rsp got %0d exp 0", viol); end
        ifa.cmd_write = 1'b1; ifa.cmd_phy_addr = 5'h0A; ifa.cmd_reg_addr = 5'h11; ifa.cmd_wdata = 16'h00FF;
        ifa.cmd_valid = 1'b1;
        reset_N = 1'b1;
        @(posedge clk_25Mz); #1;
        ifa.cmd_valid = 1'b0; ifa.cmd_wdata = 16'hFF00;
        checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL abort_accept got %b exp 1", ifa.busy); end
        exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h0A, 5'h11, 2'b10, 16'h00FF};
        run_frame({64{1'b1}}, -1);
        checks++; if (rsp_cyc != 641 || rec_o !== exp) begin errors++; $display("FAIL abort_next got %0d/%h exp 641/%h", rsp_cyc, rec_o, exp); end
    endtask

    task automatic test_short;
        logic [31:0] exp, rec;
        int n, run, bad, cyc_rsp;
        logic prev;
        exp = {2'b01, 2'b01, 5'h1F, 5'h1E, 2'b10, 16'hA5C3};
        ifb.cmd_write = 1'b1; ifb.cmd_phy_addr = 5'h1F; ifb.cmd_reg_addr = 5'h1E; ifb.cmd_wdata = 16'hA5C3;
        ifb.cmd_valid = 1'b1;
        @(posedge clk_25Mz); #1;
        ifb.cmd_valid = 1'b0; ifb.cmd_wdata = 16'h0000;
        rec = '0; n = 0; run = 0; bad = 0; cyc_rsp = 0; prev = 1'b0;
        for (int cyc = 1; cyc <= 400 && cyc_rsp == 0; cyc++) begin
            if (mdc_b === prev) run++;
            else begin
                if (run != 2) bad++;
                run = 1;
            end
            if (mdc_b && !prev) begin
                if (n < 32) rec[31-n] = mdo_b;
                n++;
            end
            if (ifb.rsp_valid) cyc_rsp = cyc;
            prev = mdc_b;
            @(posedge clk_25Mz); #1;
        end
        checks++; if (cyc_rsp != 129) begin errors++; $display("FAIL short_latency got %0d exp 129", cyc_rsp); end
        checks++; if (n != 32 || rec !== exp) begin errors++; $display("FAIL short_serial got %0d/%h exp 32/%h", n, rec, exp); end
        checks++; if (bad != 0) begin errors++; $display("FAIL short_mdc_phase got %0d exp 0", bad); end
        checks++; if (ifb.rsp_rdata !== 16'h0 || mdoe_b !== 1'b0 || mdo_b !== 1'b1) begin errors++; $display("FAIL short_idle got %h/%b%b exp 0000/01", ifb.rsp_rdata, mdoe_b, mdo_b); end
    endtask

    initial begin
        reset_N = 1'b0; enable = 1'b0; enable_b = 1'b0;
        mdi_a = 1'b1; mdi_b = 1'b1;
        ifa.cmd_valid = 1'b0; ifa.cmd_write = 1'b0; ifa.cmd_phy_addr = '0; ifa.cmd_reg_addr = '0; ifa.cmd_wdata = '0;
        ifb.cmd_valid = 1'b0; ifb.cmd_write = 1'b0; ifb.cmd_phy_addr = '0; ifb.cmd_reg_addr = '0; ifb.cmd_wdata = '0;
        test_reset();
        test_read();
        test_write();
        test_no_phy();
        test_enable_hold();
        test_reset_abort();
        test_short();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phy_mdio_master.md
PHY_MDIO_MASTER -- requirements
Module: phy_mdio_master

Interface
REQ-001 SHALL have parameter MDC_DIV, default 10, meaning clk_25Mz cycles per MDC period (even, >=4; 10 gives 2.5 MHz).
REQ-002 SHALL have parameter PRE_LEN, default 32, meaning preamble '1' bits per frame (0..32).
REQ-003 SHALL have ports: clk_25Mz  in  1  the single clock, all logic on its rising edge.
REQ-004 reset_N  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  PHY ready (driven from the reset/power-up sequencer's good_work); gates acceptance only.
REQ-006 cmd_valid  in  1; cmd_ready  out  1  command handshake.
REQ-007 cmd_write  in  1  1=write, 0=read; cmd_phy_addr  in  5; cmd_reg_addr  in  5; cmd_wdata  in  16.
REQ-008 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  16  read data; rsp_ta_err  out  1  read TA bit 2 not 0.
REQ-009 busy  out  1  frame in progress.
REQ-010 MDC  out  1; mdio_o  out  1; mdio_oe  out  1; mdio_i  in  1  management pins (external tristate).

Function
REQ-011 SHALL accept a command in a cycle where cmd_valid=1 and cmd_ready=1; cmd_ready = enable AND state IDLE.
REQ-012 SHALL latch all cmd_* fields at acceptance; later changes have no effect on the frame.
REQ-013 States: IDLE -> PRE (PRE_LEN bits; skipped if 0) -> HDR (14 bits: ST=01, OP=10 read/01 write, PHYAD, REGAD, MSB first) -> TA (2 bits) -> DATA (16 bits, MSB first) -> DONE (1 cycle) -> IDLE.
REQ-014 MDC SHALL be 0 in IDLE/DONE; in active states it is low for MDC_DIV/2 cycles then high for MDC_DIV/2 cycles per bit, first low phase starting the cycle after acceptance.
REQ-015 mdio_o/mdio_oe SHALL change only in the cycle MDC goes 1->0 (or the first low phase), so data is stable around every rising edge.
REQ-016 Write frame: mdio_oe=1 for all PRE/HDR/TA/DATA bits; TA driven 1,0; DATA = cmd_wdata.
REQ-017 Read frame: mdio_oe=1 through HDR; mdio_oe=0 for TA and DATA; mdio_i sampled in the cycle MDC goes 0->1.
REQ-018 rsp_ta_err SHALL be 1 if the sampled second TA bit of a read is 1; forced 0 for writes.
REQ-019 rsp_rdata SHALL hold the 16 sampled bits after a read, 16'h0000 after a write, stable until the next rsp_valid.
REQ-020 rsp_valid SHALL pulse in DONE, exactly (PRE_LEN+32)*MDC_DIV+1 cycles after the acceptance cycle (641 for defaults).
REQ-021 busy = (state != IDLE); cmd_valid while busy SHALL be ignored, not queued.
REQ-022 enable falling mid-frame SHALL NOT abort the frame; it only blocks the next acceptance.
REQ-023 Idle line: mdio_oe=0, mdio_o=1.
REQ-024 Bit counter 6 bits, phase counter ceil(log2(MDC_DIV)) bits; both return to 0 at each state exit, no wrap within a state.

Reset
REQ-025 reset_N=0 SHALL immediately force state IDLE, MDC=0, mdio_oe=0, mdio_o=1, cmd_ready=0, busy=0, rsp_valid=0, rsp_ta_err=0, rsp_rdata=0, counters 0.
REQ-026 Reset mid-frame SHALL abort with no rsp_valid; first acceptance is possible the cycle after reset_N rises if enable=1.

Structure
REQ-027 Package phy_mdio_pkg SHALL hold the state enum, ST/OP/TA constants and frame-length localparams.
REQ-028 One sub-module, mdio_clk_div, SHALL generate MDC and the fall/rise strobes from MDC_DIV; FSM and shift registers stay in phy_mdio_master.

Verification
REQ-029 Write phy=5'h01 reg=5'h00 data=16'h8000 -> 64 MDC periods, serial 32x'1',01,01,00001,00000,10,1000000000000000; rsp_valid at cycle 641, rsp_rdata=0.
REQ-030 Read phy=5'h01 reg=5'h02, PHY model returns TA 0 then 16'h0141 -> mdio_oe=0 from bit 46, rsp_rdata=16'h0141, rsp_ta_err=0.
REQ-031 Read with non-responding PHY (mdio_i pulled 1) -> rsp_rdata=16'hFFFF, rsp_ta_err=1.
REQ-032 cmd_valid held high through a frame, enable=0 at bit 20 -> exactly one frame, cmd_ready stays 0 after DONE until enable=1.
REQ-033 reset_N low at bit 40 of a write -> same-cycle MDC=0, mdio_oe=0, no rsp_valid; new command accepted next cycle after release.
REQ-034 PRE_LEN=0, MDC_DIV=4 -> 32-bit frame, rsp_valid at cycle 129, MDC high/low 2 cycles each.
